// File: rtl/muldiv_ctrl_pkg.sv
// Shared types for the HI/LO multiply/divide controller: decoded op codes,
// controller state encoding, widths and the muldiv-class membership test.
package muldiv_ctrl_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned DIV_ITERS = 32;
    localparam int unsigned CNT_W     = 6;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_ADD   = 4'd1,
        OP_SUB   = 4'd2,
        OP_AND   = 4'd3,
        OP_OR    = 4'd4,
        OP_SLT   = 4'd5,
        OP_LW    = 4'd6,
        OP_SW    = 4'd7,
        OP_MULT  = 4'd8,
        OP_MULTU = 4'd9,
        OP_DIV   = 4'd10,
        OP_DIVU  = 4'd11,
        OP_MTHI  = 4'd12,
        OP_MTLO  = 4'd13,
        OP_MFHI  = 4'd14,
        OP_MFLO  = 4'd15
    } op_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        DIV_BUSY = 2'd2,
        DONE     = 2'd3
    } muldiv_state_t;

    // Ops that this controller acts on; MFHI/MFLO only read hi/lo.
    function automatic logic is_muldiv(input op_t op);
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO: return 1'b1;
            default:                                             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_ctrl_div_iter.sv
// Restoring divider datapath: one quotient bit per step pulse on unsigned
// magnitudes; load primes the partial remainder and the quotient shifter.
module muldiv_ctrl_div_iter
    import muldiv_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              load,
    input  logic              step,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    logic [DATA_W-1:0] dsr;
    logic [DATA_W:0]   trial_c;
    logic [DATA_W:0]   diff_c;

    // Partial remainder shifted left with the next dividend bit pulled in.
    assign trial_c = {remainder, quotient[DATA_W-1]};
    assign diff_c  = trial_c - {1'b0, dsr};

    always_ff @(posedge clk) begin
        if (load) begin
            remainder <= '0;
            quotient  <= dividend;
            dsr       <= divisor;
        end else if (step) begin
            if (!diff_c[DATA_W]) begin
                remainder <= diff_c[DATA_W-1:0];
                quotient  <= {quotient[DATA_W-2:0], 1'b1};
            end else begin
                remainder <= trial_c[DATA_W-1:0];
                quotient  <= {quotient[DATA_W-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer for the execute stage; owns HI/LO and stalls
// the stage while busy. Define DIV_EARLY_OUT_EN to skip trivial divides.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  op_t               req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic              flush,
    output logic              stall,
    output logic              busy,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    muldiv_state_t state, state_nxt;
    logic [CNT_W-1:0] cnt;

    logic acc_c, acc_mul_c, acc_div_c, acc_mthi_c, acc_mtlo_c;
    logic div_step_c, res_wr_c;
    logic a_neg_c, b_neg_c, early_c;
    logic [DATA_W-1:0] a_mag_c, b_mag_c;

    logic signed [DATA_W:0]     mul_a, mul_b;
    logic signed [2*DATA_W-1:0] prod_c;
    logic [2*DATA_W-1:0]        mul_pipe [MUL_LAT];
    logic [2*DATA_W-1:0]        mul_res_c;

    logic op_div, div_zero, div_early, div_neg_q, div_neg_r;
    logic [DATA_W-1:0] div_a_raw, quo, rem, res_hi_c, res_lo_c;

    // Request decode; only IDLE accepts, and flush kills the request.
    assign acc_c      = (state == IDLE) && req_valid && !flush && is_muldiv(req_op);
    assign acc_mul_c  = acc_c && (req_op == OP_MULT || req_op == OP_MULTU);
    assign acc_div_c  = acc_c && (req_op == OP_DIV || req_op == OP_DIVU);
    assign acc_mthi_c = acc_c && (req_op == OP_MTHI);
    assign acc_mtlo_c = acc_c && (req_op == OP_MTLO);

    assign a_neg_c = (req_op == OP_DIV) && req_a[DATA_W-1];
    assign b_neg_c = (req_op == OP_DIV) && req_b[DATA_W-1];
    assign a_mag_c = a_neg_c ? DATA_W'(-req_a) : req_a;
    assign b_mag_c = b_neg_c ? DATA_W'(-req_b) : req_b;

`ifdef DIV_EARLY_OUT_EN
    assign early_c = (req_b == '0) || (a_mag_c < b_mag_c);
`else
    assign early_c = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (acc_mul_c) begin
                        state_nxt = MUL_BUSY;
                    end else if (acc_div_c) begin
                        state_nxt = early_c ? DONE : DIV_BUSY;
                    end
                end
                MUL_BUSY, DIV_BUSY: begin
                    if (cnt == CNT_W'(1)) begin
                        state_nxt = DONE;
                    end
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        stall      = 1'b0;
        busy       = (state != IDLE);
        div_step_c = 1'b0;
        res_wr_c   = 1'b0;
        case (state)
            IDLE:     stall = acc_mul_c || acc_div_c;
            MUL_BUSY: stall = !flush;
            DIV_BUSY: begin
                stall      = !flush;
                div_step_c = !flush;
            end
            DONE:     res_wr_c = !flush;
            default:  stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            cnt <= '0;
        end else if (acc_mul_c) begin
            cnt <= CNT_W'(MUL_LAT);
        end else if (acc_div_c) begin
            cnt <= early_c ? '0 : CNT_W'(DIV_ITERS);
        end else if ((state == MUL_BUSY || state == DIV_BUSY) && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Operand and sign-fixup capture at acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            mul_a     <= '0;
            mul_b     <= '0;
            op_div    <= 1'b0;
            div_zero  <= 1'b0;
            div_early <= 1'b0;
            div_neg_q <= 1'b0;
            div_neg_r <= 1'b0;
            div_a_raw <= '0;
        end else if (acc_mul_c) begin
            mul_a  <= {(req_op == OP_MULT) && req_a[DATA_W-1], req_a};
            mul_b  <= {(req_op == OP_MULT) && req_b[DATA_W-1], req_b};
            op_div <= 1'b0;
        end else if (acc_div_c) begin
            op_div    <= 1'b1;
            div_zero  <= (req_b == '0);
            div_early <= early_c;
            div_neg_q <= a_neg_c ^ b_neg_c;
            div_neg_r <= a_neg_c;
            div_a_raw <= req_a;
        end
    end

    // Registered product followed by a delay chain; the tail is ready by DONE.
    assign prod_c    = 64'(mul_a) * 64'(mul_b);
    assign mul_res_c = mul_pipe[MUL_LAT-1];

    always_ff @(posedge clk) begin
        mul_pipe[0] <= prod_c;
        for (int i = 1; i < int'(MUL_LAT); i++) begin
            mul_pipe[i] <= mul_pipe[i-1];
        end
    end

    muldiv_ctrl_div_iter u_div (
        .clk       (clk),
        .load      (acc_div_c),
        .step      (div_step_c),
        .dividend  (a_mag_c),
        .divisor   (b_mag_c),
        .quotient  (quo),
        .remainder (rem)
    );

    // Result select with divide sign fixups; zero divisor bypasses the fixup.
    always_comb begin
        res_hi_c = mul_res_c[2*DATA_W-1:DATA_W];
        res_lo_c = mul_res_c[DATA_W-1:0];
        if (op_div) begin
            if (div_zero) begin
                res_lo_c = '1;
                res_hi_c = div_a_raw;
            end else if (div_early) begin
                res_lo_c = '0;
                res_hi_c = div_a_raw;
            end else begin
                res_lo_c = div_neg_q ? DATA_W'(-quo) : quo;
                res_hi_c = div_neg_r ? DATA_W'(-rem) : rem;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (res_wr_c) begin
            hi <= res_hi_c;
            lo <= res_lo_c;
        end else begin
            if (acc_mthi_c) hi <= req_a;
            if (acc_mtlo_c) lo <= req_a;
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed vector table, hand-written
// flush/reset/back-to-back sequences, and randomized ops against a model.
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    localparam int unsigned MUL_LAT = 3;
`ifdef DIV_EARLY_OUT_EN
    localparam bit EARLY_EN = 1'b1;
`else
    localparam bit EARLY_EN = 1'b0;
`endif
    localparam int DIV_ST = EARLY_EN ? 1 : 33;

    logic        clk = 1'b0;
    logic        reset, req_valid, flush, stall, busy;
    op_t         req_op;
    logic [31:0] req_a, req_b, hi, lo;

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] m_hi, m_lo;

    typedef struct {
        op_t         op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_st;
    } vec_t;

    vec_t vecs[11];

    muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .flush     (flush),
        .stall     (stall),
        .busy      (busy),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Presents one instruction, holding it while stalled; returns in the cycle
    // after it leaves the stage (stall count and the cycle index of DONE).
    task automatic issue(input op_t op, input logic [31:0] a, input logic [31:0] b,
                         output int stalls, output int done_cyc);
        stalls   = 0;
        done_cyc = -1;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        for (int c = 0; c < 64; c++) begin
            #1;
            if (stall) stalls++;
            if (c == 0 && !stall) done_cyc = 0;
            else if (c > 0 && busy && !stall) done_cyc = c;
            @(negedge clk);
            if (done_cyc >= 0) break;
        end
        req_valid = 1'b0;
        req_op    = OP_NOP;
    endtask

    // Architectural reference: plain arithmetic on the model HI/LO.
    task automatic model_step(input op_t op, input logic [31:0] a, input logic [31:0] b,
                              output int st);
        longint      sa, sb, sp, ma, mb;
        logic [63:0] up;
        bit          early;
        st = 0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        case (op)
            OP_MULT: begin
                sp = sa * sb;
                m_hi = sp[63:32];
                m_lo = sp[31:0];
                st = int'(MUL_LAT) + 1;
            end
            OP_MULTU: begin
                up = 64'(a) * 64'(b);
                m_hi = up[63:32];
                m_lo = up[31:0];
                st = int'(MUL_LAT) + 1;
            end
            OP_DIV: begin
                if (b == 32'd0) begin
                    m_lo = 32'hFFFF_FFFF;
                    m_hi = a;
                end else begin
                    m_lo = 32'(sa / sb);
                    m_hi = 32'(sa % sb);
                end
                early = (b == 32'd0) || (ma < mb);
                st = (EARLY_EN && early) ? 1 : 33;
            end
            OP_DIVU: begin
                if (b == 32'd0) begin
                    m_lo = 32'hFFFF_FFFF;
                    m_hi = a;
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
                early = (b == 32'd0) || (a < b);
                st = (EARLY_EN && early) ? 1 : 33;
            end
            OP_MTHI: m_hi = a;
            OP_MTLO: m_lo = a;
            default: st = 0;
        endcase
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int  st, dc, exp_st, pick;
        bit  found;
        op_t ops[8];
        op_t op;
        logic [31:0] a, b;

        vecs[0]  = '{OP_MULT,  32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFE, int'(MUL_LAT) + 1};
        vecs[1]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'd2,         32'd1,         32'hFFFF_FFFE, int'(MUL_LAT) + 1};
        vecs[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
        vecs[3]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 33};
        vecs[4]  = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        33};
        vecs[5]  = '{OP_DIVU,  32'd3,         32'd10,        32'd3,         32'd0,         DIV_ST};
        vecs[6]  = '{OP_DIV,   32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, DIV_ST};
        vecs[7]  = '{OP_MTHI,  32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF, 0};
        vecs[8]  = '{OP_MFHI,  32'hDEAD_BEEF, 32'd9,         32'h1234_5678, 32'hFFFF_FFFF, 0};
        vecs[9]  = '{OP_MTLO,  32'hCAFE_F00D, 32'd0,         32'h1234_5678, 32'hCAFE_F00D, 0};
        vecs[10] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         int'(MUL_LAT) + 1};

        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = OP_NOP;
        req_a     = '0;
        req_b     = '0;
        flush     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_stall", 64'(stall), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);

        // Directed table; consecutive rows are issued back to back.
        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, st, dc);
            #1;
            check($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].exp_hi));
            check($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].exp_lo));
            check($sformatf("vec%0d_stalls", i), 64'(st), 64'(vecs[i].exp_st));
            check($sformatf("vec%0d_done_cycle", i), 64'(dc), 64'(vecs[i].exp_st));
        end

        issue(OP_MTHI, 32'hAAAA_5555, 32'd0, st, dc);
        issue(OP_MTLO, 32'h0F0F_0F0F, 32'd0, st, dc);
        #1;

        // Flush in cycle 5 of a divide.
        req_valid = 1'b1;
        req_op    = OP_DIVU;
        req_a     = 32'd100;
        req_b     = 32'd7;
        repeat (5) @(negedge clk);
        flush = 1'b1;
        #1;
        check("div_flush_stall", 64'(stall), 64'd0);
        @(negedge clk);
        flush     = 1'b0;
        req_valid = 1'b0;
        req_op    = OP_NOP;
        #1;
        check("div_flush_idle", 64'(busy), 64'd0);
        check("div_flush_hi", 64'(hi), 64'hAAAA_5555);
        repeat (40) @(negedge clk);
        #1;
        check("div_flush_hi_late", 64'(hi), 64'hAAAA_5555);
        check("div_flush_lo_late", 64'(lo), 64'h0F0F_0F0F);

        // Flush in the DONE cycle of a multiply.
        req_valid = 1'b1;
        req_op    = OP_MULT;
        req_a     = 32'd7;
        req_b     = 32'd9;
        found     = 1'b0;
        for (int c = 1; c <= 20 && !found; c++) begin
            @(negedge clk);
            #1;
            if (busy && !stall) found = 1'b1;
        end
        check("done_reached", 64'(found), 64'd1);
        flush = 1'b1;
        #1;
        check("done_flush_stall", 64'(stall), 64'd0);
        @(negedge clk);
        flush     = 1'b0;
        req_valid = 1'b0;
        req_op    = OP_NOP;
        #1;
        check("done_flush_idle", 64'(busy), 64'd0);
        check("done_flush_hi", 64'(hi), 64'hAAAA_5555);
        check("done_flush_lo", 64'(lo), 64'h0F0F_0F0F);

        // MULT accepted in the IDLE cycle right after a DONE.
        issue(OP_MULT, 32'd3, 32'd5, st, dc);
        issue(OP_MULT, 32'hFFFF_FFFA, 32'd7, st, dc);
        #1;
        check("b2b_stalls", 64'(st), 64'(int'(MUL_LAT) + 1));
        check("b2b_hi", 64'(hi), 64'hFFFF_FFFF);
        check("b2b_lo", 64'(lo), 64'hFFFF_FFD6);

        // Reset in the middle of a divide.
        req_valid = 1'b1;
        req_op    = OP_DIV;
        req_a     = 32'd1000;
        req_b     = 32'd3;
        repeat (10) @(negedge clk);
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = OP_NOP;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        check("midrst_stall", 64'(stall), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);

        // Randomized ops against the model, starting from reset HI/LO.
        m_hi = 32'd0;
        m_lo = 32'd0;
        ops  = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_MFHI, OP_ADD};
        for (int n = 0; n < 40; n++) begin
            op   = ops[$urandom_range(0, 7)];
            pick = int'($urandom_range(0, 3));
            a    = (pick == 1) ? 32'($urandom_range(0, 40)) : $urandom;
            pick = int'($urandom_range(0, 3));
            b    = (pick == 0) ? 32'd0 : (pick == 1) ? 32'($urandom_range(1, 20)) : $urandom;
            issue(op, a, b, st, dc);
            model_step(op, a, b, exp_st);
            #1;
            check($sformatf("rnd%0d_hi op=%0d a=%0h b=%0h", n, op, a, b), 64'(hi), 64'(m_hi));
            check($sformatf("rnd%0d_lo op=%0d a=%0h b=%0h", n, op, a, b), 64'(lo), 64'(m_lo));
            check($sformatf("rnd%0d_stalls", n), 64'(st), 64'(exp_st));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
